// File: rtl/lcd_text_attr.sv
// rtl/lcd_text_attr.sv - text-mode LCD scan controller with per-cell colour attributes and blinking cursor
`timescale 1ns/1ps
module lcd_text_attr #(
  parameter int H_ACTIVE     = 480,
  parameter int H_BP         = 43,
  parameter int H_TOTAL      = 525,
  parameter int V_ACTIVE     = 272,
  parameter int V_BP         = 12,
  parameter int V_TOTAL      = 286,
  parameter int COLS         = 60,
  parameter int ROWS         = 17,
  parameter int FONT_H       = 16,
  parameter int BLINK_FRAMES = 30,
  localparam int AW          = $clog2(COLS*ROWS),
  localparam int FW          = 7 + $clog2(FONT_H)
) (
  input  logic          PixelClk,
  input  logic          nRST,
  output logic [AW-1:0] v_adb,
  input  logic [7:0]    v_dout,
  input  logic [7:0]    a_dout,
  output logic [FW-1:0] f_ad,
  input  logic [7:0]    f_dout,
  input  logic          cursor_en,
  input  logic [7:0]    cursor_col,
  input  logic [7:0]    cursor_row,
  output logic          LCD_DE,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B,
  output logic          frame_start
);

  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int BW  = $clog2(BLINK_FRAMES);
  localparam int FHW = $clog2(FONT_H);

  // Palette index {I,R,G,B}: a set channel is full scale when I=1, else two thirds.
  function automatic logic [15:0] palette(input logic [3:0] idx);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = idx[2] ? (idx[3] ? 5'd31 : 5'd20) : 5'd0;
    g = idx[1] ? (idx[3] ? 6'd63 : 6'd42) : 6'd0;
    b = idx[0] ? (idx[3] ? 5'd31 : 5'd20) : 5'd0;
    return {r, g, b};
  endfunction

  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          frame_start_q, frame_start_d;

  logic [AW-1:0] v_adb_q, v_adb_d;
  logic [7:0]    char1_q, char1_d, attr1_q, attr1_d;
  logic          hit1_q, hit1_d;
  logic [FW-1:0] f_ad_q, f_ad_d;
  logic [7:0]    glyph1_q, glyph1_d;
  logic [7:0]    char2_q, char2_d, attr2_q, attr2_d, glyph2_q, glyph2_d;
  logic          hit2_q, hit2_d;

  logic          de_q, de_d;
  logic [15:0]   rgb_q, rgb_d;

  // Signed position decode; xf runs one cell ahead so each fetch sees its own cell index.
  int             x_c, y_c, xf_c, fcell_c, row_c;
  logic [2:0]     fphase_c;
  logic [FHW-1:0] yrow_c;
  logic [AW-1:0]  addr_c;
  logic           visible_c, text_c, fetch_c, hit_c;

  assign x_c       = int'(hc_q) - H_BP;
  assign y_c       = int'(vc_q) - V_BP;
  assign xf_c      = x_c + 8;
  assign fcell_c   = xf_c >>> 3;
  assign row_c     = y_c >>> FHW;
  assign fphase_c  = xf_c[2:0];
  assign yrow_c    = y_c[FHW-1:0];
  assign addr_c    = AW'(row_c * COLS + fcell_c);
  assign visible_c = (x_c >= 0) && (x_c < H_ACTIVE) && (y_c >= 0) && (y_c < V_ACTIVE);
  assign text_c    = visible_c && (x_c < COLS*8) && (y_c < ROWS*FONT_H);
  assign fetch_c   = (y_c >= 0) && (y_c < V_ACTIVE) && (y_c < ROWS*FONT_H) &&
                     (xf_c >= 0) && (fcell_c < COLS);
  // Full-width compare so out-of-grid cursor coordinates can never alias onto a cell.
  assign hit_c     = cursor_en && (int'(cursor_col) == fcell_c) && (int'(cursor_row) == row_c);

  // Scan counters, frame pulse and blink phase.
  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;
    frame_start_d = (hc_q == '0) && (vc_q == '0);
    if (hc_q == HW'(H_TOTAL-1)) begin
      hc_d = '0;
      if (vc_q == VW'(V_TOTAL-1)) begin
        vc_d = '0;
        if (blink_cnt_q == BW'(BLINK_FRAMES-1)) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        vc_d = vc_q + 1'b1;
      end
    end else begin
      hc_d = hc_q + 1'b1;
    end
  end

  // Cell fetch pipeline: address, char/attr, font address, glyph, then hand-off at the cell boundary.
  always_comb begin
    v_adb_d  = v_adb_q;
    char1_d  = char1_q;
    attr1_d  = attr1_q;
    hit1_d   = hit1_q;
    f_ad_d   = f_ad_q;
    glyph1_d = glyph1_q;
    char2_d  = char2_q;
    attr2_d  = attr2_q;
    glyph2_d = glyph2_q;
    hit2_d   = hit2_q;
    if (fetch_c) begin
      case (fphase_c)
        3'd1: v_adb_d = addr_c;
        3'd3: begin
          char1_d = v_dout;
          attr1_d = a_dout;
        end
        3'd4: begin
          hit1_d = hit_c;
          f_ad_d = {char1_q[6:0], yrow_c};
        end
        3'd6: glyph1_d = f_dout;
        3'd7: begin
          char2_d  = char1_q;
          attr2_d  = attr1_q;
          glyph2_d = glyph1_q;
          hit2_d   = hit1_q;
        end
        default: ;
      endcase
    end
  end

  // Pixel colour from the second-stage cell registers.
  logic [3:0] fg_c, bg_c, idx_c;
  logic       bit_c;
  always_comb begin
    fg_c = attr2_q[3:0];
    bg_c = attr2_q[7:4];
    if (hit2_q && blink_on_q) begin
      fg_c = attr2_q[7:4];
      bg_c = attr2_q[3:0];
    end
    bit_c = glyph2_q[3'd7 - x_c[2:0]];
    idx_c = bit_c ? fg_c : bg_c;
    de_d  = visible_c;
    rgb_d = '0;
    if (text_c) begin
      rgb_d = char2_q[7] ? 16'hF800 : palette(idx_c);
    end
  end

  // Scan state registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      hc_q          <= '0;
      vc_q          <= '0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Fetch pipeline and output registers.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      v_adb_q  <= '0;
      char1_q  <= '0;
      attr1_q  <= '0;
      hit1_q   <= 1'b0;
      f_ad_q   <= '0;
      glyph1_q <= '0;
      char2_q  <= '0;
      attr2_q  <= '0;
      glyph2_q <= '0;
      hit2_q   <= 1'b0;
      de_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      v_adb_q  <= v_adb_d;
      char1_q  <= char1_d;
      attr1_q  <= attr1_d;
      hit1_q   <= hit1_d;
      f_ad_q   <= f_ad_d;
      glyph1_q <= glyph1_d;
      char2_q  <= char2_d;
      attr2_q  <= attr2_d;
      glyph2_q <= glyph2_d;
      hit2_q   <= hit2_d;
      de_q     <= de_d;
      rgb_q    <= rgb_d;
    end
  end

  assign v_adb       = v_adb_q;
  assign f_ad        = f_ad_q;
  assign LCD_DE      = de_q;
  assign LCD_R       = rgb_q[15:11];
  assign LCD_G       = rgb_q[10:5];
  assign LCD_B       = rgb_q[4:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_text_attr.sv
// tb/tb_lcd_text_attr.sv - directed bench for lcd_text_attr on a reduced-size panel
`timescale 1ns/1ps
module tb_lcd_text_attr;

  localparam int H_ACTIVE = 72;
  localparam int H_BP     = 10;
  localparam int H_TOTAL  = 90;
  localparam int V_ACTIVE = 14;
  localparam int V_BP     = 2;
  localparam int V_TOTAL  = 18;
  localparam int COLS     = 8;
  localparam int ROWS     = 3;
  localparam int FONT_H   = 4;
  localparam int BLINK    = 3;
  localparam int AW       = 5;
  localparam int FW       = 9;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int DE_PER_FRAME = H_ACTIVE * V_ACTIVE;

  logic          PixelClk;
  logic          nRST;
  logic [AW-1:0] v_adb;
  logic [7:0]    v_dout, a_dout, f_dout;
  logic [FW-1:0] f_ad;
  logic          cursor_en;
  logic [7:0]    cursor_col, cursor_row;
  logic          LCD_DE;
  logic [4:0]    LCD_R, LCD_B;
  logic [5:0]    LCD_G;
  logic          frame_start;

  int checks   = 0;
  int failures = 0;

  logic [7:0]    char_mem [0:31];
  logic [7:0]    attr_mem [0:31];
  logic [7:0]    font_mem [0:511];

  logic [15:0]   cap_rgb [0:FRAME-1];
  logic          cap_de  [0:FRAME-1];
  logic [AW-1:0] cap_adb [0:FRAME-1];

  lcd_text_attr #(
    .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_TOTAL(H_TOTAL),
    .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .V_TOTAL(V_TOTAL),
    .COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H), .BLINK_FRAMES(BLINK)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST),
    .v_adb(v_adb), .v_dout(v_dout), .a_dout(a_dout),
    .f_ad(f_ad), .f_dout(f_dout),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .LCD_DE(LCD_DE), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .frame_start(frame_start)
  );

  initial PixelClk = 1'b0;
  always #5 PixelClk = ~PixelClk;

  // Memories with one cycle of registered read latency.
  always @(posedge PixelClk) begin
    v_dout <= char_mem[v_adb];
    a_dout <= attr_mem[v_adb];
    f_dout <= font_mem[f_ad];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Sample index of pixel (x,y) relative to the frame_start cycle.
  function automatic int pk(input int x, input int y);
    return (V_BP + y) * H_TOTAL + H_BP + x;
  endfunction

  task automatic scene(input logic [7:0] c, input logic [7:0] a);
    @(negedge PixelClk);
    nRST = 1'b0;
    for (int i = 0; i < 32; i++) begin
      char_mem[i] = c;
      attr_mem[i] = a;
    end
    for (int i = 0; i < 512; i++) font_mem[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(negedge PixelClk);
    nRST = 1'b1;
  endtask

  task automatic capture_frame(output int de_cnt, output int fs_cnt, output int waited, output bit timed_out);
    de_cnt = 0; fs_cnt = 0; waited = 0; timed_out = 1'b0;
    @(negedge PixelClk);
    while (frame_start !== 1'b1 && waited < 2*FRAME) begin
      @(negedge PixelClk);
      waited++;
    end
    if (frame_start !== 1'b1) timed_out = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge PixelClk);
      cap_rgb[i] = {LCD_R, LCD_G, LCD_B};
      cap_de[i]  = LCD_DE;
      cap_adb[i] = v_adb;
      if (LCD_DE === 1'b1) de_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; cursor_en = 1'b0; cursor_col = 8'd0; cursor_row = 8'd0;
    repeat (3) @(negedge PixelClk);
    checks++; if (LCD_DE !== 1'b0) begin failures++; $display("FAIL rst_de got %b want 0", LCD_DE); end
    checks++; if ({LCD_R, LCD_G, LCD_B} !== 16'h0) begin failures++; $display("FAIL rst_rgb got %h want 0000", {LCD_R, LCD_G, LCD_B}); end
    checks++; if (v_adb !== '0) begin failures++; $display("FAIL rst_v_adb got %0d want 0", v_adb); end
    checks++; if (f_ad !== '0) begin failures++; $display("FAIL rst_f_ad got %0d want 0", f_ad); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs got %b want 0", frame_start); end
    nRST = 1'b1;
    @(posedge PixelClk); #1;
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL rel_fs_first got %b want 1", frame_start); end
    @(posedge PixelClk); #1;
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rel_fs_second got %b want 0", frame_start); end
  endtask

  task automatic test_frame_timing();
    int de, fs, w, mx;
    bit to;
    int xs [7] = '{3, 4, 2, 5, 11, 59, 3};
    int ys [7] = '{0, 0, 0, 0, 0,  0,  1};
    logic [15:0] es [7] = '{16'h07E0, 16'h07E0, 16'h0000, 16'h0000, 16'h07E0, 16'h07E0, 16'h0000};
    int k0;
    scene(8'h41, 8'h0A);
    font_mem[260] = 8'h18;
    release_reset();
    capture_frame(de, fs, w, to);
    checks++; if (to) begin failures++; $display("FAIL ft_timeout got timeout want frame_start"); end
    checks++; if (de != DE_PER_FRAME) begin failures++; $display("FAIL ft_de_count got %0d want %0d", de, DE_PER_FRAME); end
    checks++; if (fs != 1) begin failures++; $display("FAIL ft_fs_count got %0d want 1", fs); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cap_rgb[pk(xs[i], ys[i])] !== es[i]) begin
        failures++; $display("FAIL ft_pix(%0d,%0d) got %h want %h", xs[i], ys[i], cap_rgb[pk(xs[i], ys[i])], es[i]);
      end
    end
    checks++; if (cap_de[pk(0, 0)] !== 1'b1) begin failures++; $display("FAIL ft_de_first got %b want 1", cap_de[pk(0, 0)]); end
    checks++; if (cap_de[pk(-1, 0)] !== 1'b0) begin failures++; $display("FAIL ft_de_left got %b want 0", cap_de[pk(-1, 0)]); end
    checks++; if (cap_de[pk(72, 0)] !== 1'b0) begin failures++; $display("FAIL ft_de_right got %b want 0", cap_de[pk(72, 0)]); end
    checks++; if (cap_de[pk(0, -1)] !== 1'b0) begin failures++; $display("FAIL ft_de_top got %b want 0", cap_de[pk(0, -1)]); end
    checks++; if (cap_de[pk(0, 14)] !== 1'b0) begin failures++; $display("FAIL ft_de_bottom got %b want 0", cap_de[pk(0, 14)]); end
    checks++; if (cap_de[pk(71, 13)] !== 1'b1) begin failures++; $display("FAIL ft_de_last got %b want 1", cap_de[pk(71, 13)]); end
    // v_adb on line y=FONT_H: cell 0 address appears at hc=H_BP-6, sample index is hc-1.
    k0 = (V_BP + FONT_H) * H_TOTAL + (H_BP - 6) - 1;
    checks++; if (cap_adb[k0-1] !== 5'd7) begin failures++; $display("FAIL adb_before got %0d want 7", cap_adb[k0-1]); end
    for (int c = 0; c < COLS; c++) begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (cap_adb[k0 + 8*c + j] !== 5'(8 + c)) begin
          failures++; $display("FAIL adb_seq c=%0d j=%0d got %0d want %0d", c, j, cap_adb[k0 + 8*c + j], 8 + c);
        end
      end
    end
    mx = 0;
    for (int i = 0; i < FRAME; i++) if (int'(cap_adb[i]) > mx) mx = int'(cap_adb[i]);
    checks++; if (mx != COLS*ROWS - 1) begin failures++; $display("FAIL adb_max got %0d want %0d", mx, COLS*ROWS - 1); end
    capture_frame(de, fs, w, to);
    checks++; if (w != 0 || to) begin failures++; $display("FAIL ft_period got wait=%0d want 0", w); end
    checks++; if (fs != 1) begin failures++; $display("FAIL ft_fs_count2 got %0d want 1", fs); end
    checks++; if (de != DE_PER_FRAME) begin failures++; $display("FAIL ft_de_count2 got %0d want %0d", de, DE_PER_FRAME); end
  endtask

  task automatic test_palette_border();
    int de, fs, w;
    bit to;
    int xs [8] = '{3, 0, 60, 63, 64, 71, 0, 0};
    int ys [8] = '{0, 0, 8, 11, 0, 5, 12, 13};
    logic [15:0] es [8] = '{16'h0540, 16'hA000, 16'h0540, 16'hA000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    scene(8'h41, 8'h42);
    font_mem[260] = 8'h18;
    release_reset();
    capture_frame(de, fs, w, to);
    checks++; if (to) begin failures++; $display("FAIL pal_timeout got timeout want frame_start"); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cap_rgb[pk(xs[i], ys[i])] !== es[i]) begin
        failures++; $display("FAIL pal_pix(%0d,%0d) got %h want %h", xs[i], ys[i], cap_rgb[pk(xs[i], ys[i])], es[i]);
      end
    end
    checks++; if (cap_de[pk(64, 0)] !== 1'b1) begin failures++; $display("FAIL pal_border_de got %b want 1", cap_de[pk(64, 0)]); end
    checks++; if (cap_de[pk(0, 12)] !== 1'b1) begin failures++; $display("FAIL pal_lower_de got %b want 1", cap_de[pk(0, 12)]); end
  endtask

  task automatic test_red_cell();
    int de, fs, w;
    bit to;
    int xs [6] = '{39, 35, 48, 51, 43, 40};
    int ys [6] = '{0, 0, 0, 0, 4, 4};
    logic [15:0] es [6] = '{16'hA000, 16'h0540, 16'hA000, 16'h0540, 16'h0540, 16'hA000};
    scene(8'h41, 8'h42);
    font_mem[260] = 8'h18;
    char_mem[5] = 8'h80;
    release_reset();
    capture_frame(de, fs, w, to);
    checks++; if (to) begin failures++; $display("FAIL red_timeout got timeout want frame_start"); end
    for (int y = 0; y < FONT_H; y++) begin
      for (int x = 40; x < 48; x++) begin
        checks++;
        if (cap_rgb[pk(x, y)] !== 16'hF800) begin
          failures++; $display("FAIL red_pix(%0d,%0d) got %h want f800", x, y, cap_rgb[pk(x, y)]);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_rgb[pk(xs[i], ys[i])] !== es[i]) begin
        failures++; $display("FAIL red_nbr(%0d,%0d) got %h want %h", xs[i], ys[i], cap_rgb[pk(xs[i], ys[i])], es[i]);
      end
    end
  endtask

  task automatic test_cursor_blink();
    int de, fs, w;
    bit to;
    logic [15:0] exp_c;
    scene(8'h41, 8'h0F);
    for (int r = 0; r < FONT_H; r++) font_mem[260 + r] = 8'hFF;
    cursor_en = 1'b1; cursor_col = 8'd2; cursor_row = 8'd1;
    release_reset();
    for (int f = 0; f < 7; f++) begin
      capture_frame(de, fs, w, to);
      exp_c = (f < BLINK || f == 2*BLINK) ? 16'h0000 : 16'hFFFF;
      checks++; if (to) begin failures++; $display("FAIL blink_timeout f=%0d got timeout want frame_start", f); end
      checks++; if (cap_rgb[pk(16, 4)] !== exp_c) begin failures++; $display("FAIL blink_cur_a f=%0d got %h want %h", f, cap_rgb[pk(16, 4)], exp_c); end
      checks++; if (cap_rgb[pk(23, 7)] !== exp_c) begin failures++; $display("FAIL blink_cur_b f=%0d got %h want %h", f, cap_rgb[pk(23, 7)], exp_c); end
      checks++; if (cap_rgb[pk(24, 4)] !== 16'hFFFF) begin failures++; $display("FAIL blink_right f=%0d got %h want ffff", f, cap_rgb[pk(24, 4)]); end
      checks++; if (cap_rgb[pk(16, 3)] !== 16'hFFFF) begin failures++; $display("FAIL blink_above f=%0d got %h want ffff", f, cap_rgb[pk(16, 3)]); end
    end
  endtask

  task automatic test_cursor_offgrid();
    int de, fs, w;
    bit to;
    scene(8'h41, 8'h0F);
    for (int r = 0; r < FONT_H; r++) font_mem[260 + r] = 8'hFF;
    cursor_en = 1'b1; cursor_col = 8'd8; cursor_row = 8'd1;
    release_reset();
    capture_frame(de, fs, w, to);
    checks++; if (cap_rgb[pk(0, 4)] !== 16'hFFFF) begin failures++; $display("FAIL off_col0 got %h want ffff", cap_rgb[pk(0, 4)]); end
    checks++; if (cap_rgb[pk(16, 4)] !== 16'hFFFF) begin failures++; $display("FAIL off_col2 got %h want ffff", cap_rgb[pk(16, 4)]); end
    cursor_en = 1'b0; cursor_col = 8'd2; cursor_row = 8'd1;
    capture_frame(de, fs, w, to);
    checks++; if (cap_rgb[pk(16, 4)] !== 16'hFFFF) begin failures++; $display("FAIL off_disabled got %h want ffff", cap_rgb[pk(16, 4)]); end
    cursor_en = 1'b1;
    capture_frame(de, fs, w, to);
    checks++; if (to) begin failures++; $display("FAIL off_timeout got timeout want frame_start"); end
    checks++; if (cap_rgb[pk(16, 4)] !== 16'h0000) begin failures++; $display("FAIL off_enabled got %h want 0000", cap_rgb[pk(16, 4)]); end
    cursor_en = 1'b0;
  endtask

  task automatic test_midline_reset();
    int de, fs, w, n;
    bit to;
    n = 0;
    @(negedge PixelClk);
    while (frame_start !== 1'b1 && n < 2*FRAME) begin
      @(negedge PixelClk);
      n++;
    end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL mid_sync got no frame_start want frame_start"); end
    repeat (pk(20, 2)) @(negedge PixelClk);
    checks++; if (LCD_DE !== 1'b1 || {LCD_R, LCD_G, LCD_B} !== 16'hFFFF) begin
      failures++; $display("FAIL mid_before got de=%b rgb=%h want de=1 rgb=ffff", LCD_DE, {LCD_R, LCD_G, LCD_B});
    end
    #2 nRST = 1'b0;
    #1;
    checks++; if (LCD_DE !== 1'b0) begin failures++; $display("FAIL mid_de got %b want 0", LCD_DE); end
    checks++; if ({LCD_R, LCD_G, LCD_B} !== 16'h0) begin failures++; $display("FAIL mid_rgb got %h want 0000", {LCD_R, LCD_G, LCD_B}); end
    checks++; if (v_adb !== '0) begin failures++; $display("FAIL mid_v_adb got %0d want 0", v_adb); end
    checks++; if (f_ad !== '0) begin failures++; $display("FAIL mid_f_ad got %0d want 0", f_ad); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL mid_fs got %b want 0", frame_start); end
    repeat (3) @(negedge PixelClk);
    nRST = 1'b1;
    @(posedge PixelClk); #1;
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL mid_fs_first got %b want 1", frame_start); end
    capture_frame(de, fs, w, to);
    checks++; if (w != 0 || to) begin failures++; $display("FAIL mid_wait got %0d want 0", w); end
    checks++; if (de != DE_PER_FRAME) begin failures++; $display("FAIL mid_de_count got %0d want %0d", de, DE_PER_FRAME); end
    checks++; if (fs != 1) begin failures++; $display("FAIL mid_fs_count got %0d want 1", fs); end
    checks++; if (cap_rgb[pk(16, 4)] !== 16'hFFFF) begin failures++; $display("FAIL mid_pix got %h want ffff", cap_rgb[pk(16, 4)]); end
  endtask

  initial begin
    nRST = 1'b0;
    cursor_en = 1'b0; cursor_col = 8'd0; cursor_row = 8'd0;
    for (int i = 0; i < 32; i++) begin
      char_mem[i] = 8'h00;
      attr_mem[i] = 8'h00;
    end
    for (int i = 0; i < 512; i++) font_mem[i] = 8'h00;
    test_reset();
    test_frame_timing();
    test_palette_border();
    test_red_cell();
    test_cursor_blink();
    test_cursor_offgrid();
    test_midline_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
